// File: rtl/store_dataframe_fifo.sv
// Multi-frame pixel buffer: captures a wide dataframe in one cycle and presents it
// as a first-word-fall-through stream of narrow readout words with frame markers.
module store_dataframe_fifo #(
    parameter  int FRAME_W   = 448,
    parameter  int WORD_W    = 21,
    parameter  int DEPTH     = 4,
    parameter  int OVERWRITE = 0,
    localparam int NWORDS    = (FRAME_W + WORD_W - 1) / WORD_W,
    localparam int NE_W      = $clog2(DEPTH * NWORDS + 1),
    localparam int NF_W      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] data_in,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [WORD_W-1:0]  data_out,
    output logic               valid_out,
    output logic               first_out,
    output logic               last_out,
    output logic [NE_W-1:0]    num_elem,
    output logic [NF_W-1:0]    num_frames,
    output logic               full,
    output logic               empty,
    output logic               err_overwr,
    output logic [7:0]         err_cnt
);

    localparam int PAD_W = NWORDS * WORD_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WI_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NF_W-1:0]  nfr_q, nfr_d;
    logic [WI_W-1:0]  widx_q, widx_d;
    logic             err_q, err_d;
    logic [7:0]       ecnt_q, ecnt_d;

    logic [PAD_W-1:0]  mem_q [DEPTH];
    logic [PAD_W-1:0]  head_w;
    logic [WORD_W-1:0] words_w [NWORDS];

    logic empty_w, full_w, head_last_w;
    logic pop_w, pop_last_w, blocked_w, ovw_w, wr_acc_w, store_w, free_w;

    assign empty_w     = (nfr_q == '0);
    assign full_w      = (nfr_q == NF_W'(DEPTH));
    assign head_last_w = (widx_q == WI_W'(NWORDS - 1));
    assign pop_w       = rd_en && !empty_w;
    assign pop_last_w  = pop_w && head_last_w;
    // A write into a full buffer is only clean if the head frame leaves on this edge.
    assign blocked_w   = wr_en && full_w && !pop_last_w;
    assign ovw_w       = blocked_w && (OVERWRITE != 0);
    assign wr_acc_w    = wr_en && !blocked_w;
    assign store_w     = wr_acc_w || ovw_w;
    assign free_w      = pop_last_w || ovw_w;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        nfr_d  = nfr_q;
        widx_d = widx_q;
        if (store_w)
            wptr_d = wptr_q + 1'b1;
        if (free_w)
            rptr_d = rptr_q + 1'b1;
        // Overwrite swaps head for tail, so the frame count is untouched.
        if (wr_acc_w && !pop_last_w)
            nfr_d = nfr_q + 1'b1;
        else if (!wr_acc_w && pop_last_w)
            nfr_d = nfr_q - 1'b1;
        if (free_w)
            widx_d = '0;
        else if (pop_w)
            widx_d = widx_q + 1'b1;
        err_d  = blocked_w;
        ecnt_d = blocked_w ? sat_inc8(ecnt_q) : ecnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            nfr_q  <= '0;
            widx_q <= '0;
            err_q  <= 1'b0;
            ecnt_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            nfr_q  <= nfr_d;
            widx_q <= widx_d;
            err_q  <= err_d;
            ecnt_q <= ecnt_d;
        end
    end

    // Frames are stored zero-padded to a whole number of words.
    always_ff @(posedge clk) begin
        if (store_w)
            mem_q[wptr_q] <= PAD_W'(data_in);
    end

    assign head_w = mem_q[rptr_q];

    always_comb begin
        for (int k = 0; k < NWORDS; k++)
            words_w[k] = head_w[k*WORD_W +: WORD_W];
    end

    assign valid_out  = !empty_w;
    assign data_out   = empty_w ? '0 : words_w[widx_q];
    assign first_out  = !empty_w && (widx_q == '0);
    assign last_out   = !empty_w && head_last_w;
    assign num_elem   = NE_W'(nfr_q) * NE_W'(NWORDS) - NE_W'(widx_q);
    assign num_frames = nfr_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign err_overwr = err_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: doc/store_dataframe_fifo.md
# store_dataframe_fifo

Parametrised multi-frame pixel buffer that captures wide pixel dataframes in one cycle and serialises them into narrow readout words for the downstream link. It sits between the pixel array frame capture and the serial/readout interface. It is the generalised successor of the single-frame dataframe store: configurable frame and word widths, multi-frame depth, per-word frame markers, and a selectable full-buffer policy (drop-new or overwrite-oldest) with error counting.

## Interface
- FRAME_W, 448, width of one captured dataframe in bits
- WORD_W, 21, width of one readout word in bits
- DEPTH, 4, number of frames stored; power of two, ≥2
- OVERWRITE, 0, full policy: 0 = drop incoming frame, 1 = discard oldest frame
- Derived: NWORDS = ceil(FRAME_W/WORD_W), 22 at defaults; NE_W = clog2(DEPTH*NWORDS+1), 7 at defaults; NF_W = clog2(DEPTH+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_in  in  FRAME_W  frame to store
- wr_en  in  1  store data_in at this edge; one frame per cycle while high
- rd_en  in  1  pop the presented word
- data_out  out  WORD_W  current word; 0 when valid_out low
- valid_out  out  1  data_out holds a valid word
- first_out  out  1  data_out is word 0 of a frame
- last_out  out  1  data_out is word NWORDS-1 of a frame
- num_elem  out  NE_W  words remaining in buffer
- num_frames  out  NF_W  frames held, including a partially read head frame
- full  out  1  num_frames == DEPTH
- empty  out  1  num_frames == 0
- err_overwr  out  1  one-cycle pulse on a dropped or overwritten frame
- err_cnt  out  8  saturating count of err_overwr pulses

## Operation
- Storage: DEPTH frame slots, circular write/read pointers, frame count, head word index widx (0..NWORDS-1).
- Word k of a frame = data_in[k*WORD_W +: WORD_W], LSB first. Bits at or above FRAME_W read as 0 (zero-padded last word).
- First-word-fall-through: valid_out = !empty; data_out = word widx of the head slot.
- Pop occurs when rd_en && valid_out. rd_en while empty is ignored with no error.
  - widx < NWORDS-1: widx increments.
  - widx == NWORDS-1: head frame is freed, read pointer advances, widx goes to 0.
- first_out = valid_out && widx==0; last_out = valid_out && widx==NWORDS-1.
- num_elem = num_frames*NWORDS − widx.
- Write when not full: frame is stored and num_frames increments, unless a frame is freed in the same cycle, in which case num_frames is unchanged.
- Write when full, with a pop of the last word in the same cycle: the write is accepted and no error is raised.
- Write when full, with no frame freed that cycle:
  - OVERWRITE=0: incoming frame is dropped and storage is unchanged. Any concurrent mid-frame pop proceeds normally.
  - OVERWRITE=1: the oldest (head) frame is discarded, including any partially read words, and any concurrent pop is void. The read pointer advances, widx goes to 0, the new frame is written, and num_frames stays DEPTH.
  - Both policies: err_overwr pulses and err_cnt increments, saturating at 255.
- DEPTH=1 is not supported.

## Timing
- Reset, asynchronous, any time including mid-frame: pointers, widx and counts clear immediately. Storage contents are not reset.
- Output values during and after reset: valid_out 0, data_out 0, first_out 0, last_out 0, num_elem 0, num_frames 0, full 0, empty 1, err_overwr 0, err_cnt 0.
- Write latency: a frame written at edge N into an empty buffer gives valid_out=1 with word 0 on data_out after edge N.
- Sustained throughput: one word per cycle while rd_en is held high. A frame drains in NWORDS cycles.
- Status outputs (num_elem, num_frames, full, empty, first_out, last_out) are derived from registered state and settle after each edge.
- err_overwr is registered: it is high for exactly the one cycle following the offending edge.

## Test plan
- Reset; write one all-ones frame; hold rd_en=1 → 22 words. Words 0–20 = 21'h1FFFFF and word 21 = 21'h00007F. first_out on word 0, last_out on word 21, then empty=1 and num_elem=0.
- Write frame {28{16'h00ff}} and read word 0 → data_out = 21'h1F00FF. num_elem steps 22→21 on the pop.
- OVERWRITE=0: four writes with rd_en=0 → full=1, num_elem=88. A fifth write → err_overwr high one cycle, err_cnt=1. Readout then returns frames 1–4 unchanged.
- Full buffer with widx=21 and rd_en=1 in the same cycle as a write → no error, num_frames stays 4, first_out=1 with frame 2 data.
- OVERWRITE=1: full buffer, pop 5 words, then write frame 5 → err_overwr pulse, num_elem=88, data_out = frame 2 word 0, and frame 5 is the last frame read out.
- Assert rst while widx=10 → all outputs at reset values in the same cycle. Release, write one frame → word 0 is presented and num_elem=22.
